// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the instruction fetch unit
package core_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] RV_NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2,
        STALL = 2'd3
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            fault;
    } ifu_out_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - imem request/response, redirect and decode channels of the fetch unit
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_rsp_valid;
    logic [XLEN-1:0] ifu_rsp_data;
    logic            ifu_rsp_err;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            ifu_out_valid;
    logic            ifu_out_ready;
    logic [XLEN-1:0] ifu_out_inst;
    logic [XLEN-1:0] ifu_out_pc;
    logic            ifu_out_fault;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  redirect, redirect_pc,
        output ifu_out_valid, ifu_out_inst, ifu_out_pc, ifu_out_fault,
        input  ifu_out_ready
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready,
        output ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output redirect, redirect_pc,
        input  ifu_out_valid, ifu_out_inst, ifu_out_pc, ifu_out_fault,
        output ifu_out_ready
    );

endinterface

// File: rtl/ifu_fetch_out_buf.sv
// rtl/ifu_fetch_out_buf.sv - 1-entry valid/ready register slice between fetch and decode
import core_pkg::*;

module ifu_out_buf (
    input  logic     clk,
    input  logic     rst_b,
    input  logic     flush,
    input  logic     wr_valid,
    output logic     wr_ready,
    input  ifu_out_t wr_data,
    output logic     rd_valid,
    input  logic     rd_ready,
    output ifu_out_t rd_data
);

    // Writable when empty or when the held entry leaves this cycle.
    assign wr_ready = ~rd_valid | rd_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            rd_valid <= 1'b0;
        end else if (wr_valid) begin
            rd_valid <= 1'b1;
            rd_data  <= wr_data;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch PC owner: issues imem word reads and feeds decode through a 1-entry buffer
import core_pkg::*;

module ifu_fetch #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = core_pkg::RESET_VECTOR
) (
    input  logic         clk,
    input  logic         rst_b,
    ifu_fetch_if.master  bus
);

    ifu_state_e      state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            req_ok;
    logic            req_hs;
    logic            buf_wr_valid;
    logic            buf_wr_ready;
    ifu_out_t        buf_wr_data;
    ifu_out_t        buf_rd_data;
    logic            buf_rd_valid;

    // A request only goes out when the buffer is guaranteed empty by the time its response lands.
    assign req_ok = rst_b && (state == REQ) && buf_wr_ready && (fetch_pc[1:0] == 2'b00);
    assign req_hs = req_ok && bus.ifu_req_ready;

    assign bus.ifu_req_valid = req_ok;
    assign bus.ifu_req_addr  = fetch_pc;

    always_comb begin
        state_nxt    = state;
        buf_wr_valid = 1'b0;
        buf_wr_data  = '{inst: RV_NOP, pc: fetch_pc, fault: 1'b1};
        case (state)
            REQ: begin
                if (fetch_pc[1:0] != 2'b00) begin
                    if (buf_wr_ready) begin
                        buf_wr_valid = 1'b1;
                        state_nxt    = STALL;
                    end
                end else if (req_hs) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.ifu_rsp_valid) begin
                    buf_wr_valid = 1'b1;
                    if (bus.ifu_rsp_err) begin
                        buf_wr_data = '{inst: RV_NOP, pc: req_pc, fault: 1'b1};
                        state_nxt   = STALL;
                    end else begin
                        buf_wr_data = '{inst: bus.ifu_rsp_data, pc: req_pc, fault: 1'b0};
                        state_nxt   = REQ;
                    end
                end
            end
            FLUSH: begin
                if (bus.ifu_rsp_valid) state_nxt = REQ;
            end
            default: ;
        endcase

        // Redirect overrides everything; an outstanding response must be swallowed exactly once.
        if (bus.redirect) begin
            buf_wr_valid = 1'b0;
            case (state)
                WAIT, FLUSH: state_nxt = bus.ifu_rsp_valid ? REQ : FLUSH;
                REQ:         state_nxt = req_hs ? FLUSH : REQ;
                default:     state_nxt = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= REQ;
            fetch_pc <= RESET_VECTOR;
            req_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (bus.redirect)
                fetch_pc <= bus.redirect_pc;
            else if (req_hs)
                fetch_pc <= fetch_pc + {{(XLEN-3){1'b0}}, 3'd4};
            if (req_hs)
                req_pc <= fetch_pc;
        end
    end

    ifu_out_buf u_out_buf (
        .clk      (clk),
        .rst_b    (rst_b),
        .flush    (bus.redirect),
        .wr_valid (buf_wr_valid),
        .wr_ready (buf_wr_ready),
        .wr_data  (buf_wr_data),
        .rd_valid (buf_rd_valid),
        .rd_ready (bus.ifu_out_ready),
        .rd_data  (buf_rd_data)
    );

    assign bus.ifu_out_valid = buf_rd_valid;
    assign bus.ifu_out_inst  = buf_rd_data.inst;
    assign bus.ifu_out_pc    = buf_rd_data.pc;
    assign bus.ifu_out_fault = buf_rd_data.fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed scoreboard bench for ifu_fetch with a behavioural imem
import core_pkg::*;

module tb_ifu_fetch;

    logic clk;
    logic rst_b;

    ifu_fetch_if #(.XLEN(32)) bus ();

    ifu_fetch #(.XLEN(32), .RESET_VECTOR(32'h8000_0000)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    ifu_out_t    sb[$];
    int          dq[$];

    // imem model controls
    int          grant_left = 0;
    int          rsp_lat    = 1;
    logic [31:0] err_addr   = 32'h1;
    logic        hs_seen    = 1'b0;
    logic [31:0] hs_addr    = '0;
    logic        pend       = 1'b0;
    int          cnt        = 0;
    logic [31:0] pend_addr  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic ifu_out_t exp_ok(input logic [31:0] a);
        return '{inst: mem_word(a), pc: a, fault: 1'b0};
    endfunction

    function automatic ifu_out_t exp_flt(input logic [31:0] a);
        return '{inst: 32'h0000_0013, pc: a, fault: 1'b1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_req_hs(input string tag, input int bound);
        int n = 0;
        @(negedge clk);
        while (!(bus.ifu_req_valid && bus.ifu_req_ready) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_hs_seen"}, 32'(bus.ifu_req_valid && bus.ifu_req_ready), 32'd1);
    endtask

    task automatic wait_out_valid(input string tag, input int bound);
        int n = 0;
        @(negedge clk);
        while (!bus.ifu_out_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, 32'(bus.ifu_out_valid), 32'd1);
    endtask

    always @(posedge clk) cyc++;

    assign bus.ifu_req_ready = (grant_left > 0);

    always @(negedge clk) begin
        hs_seen = bus.ifu_req_valid && bus.ifu_req_ready;
        hs_addr = bus.ifu_req_addr;
    end

    // Responds rsp_lat cycles after the accepting edge with a single-cycle pulse.
    always @(posedge clk) begin
        #1;
        bus.ifu_rsp_valid = 1'b0;
        if (hs_seen) begin
            grant_left--;
            pend      = 1'b1;
            cnt       = rsp_lat;
            pend_addr = hs_addr;
        end
        if (pend) begin
            if (cnt <= 1) begin
                bus.ifu_rsp_valid = 1'b1;
                bus.ifu_rsp_data  = mem_word(pend_addr);
                bus.ifu_rsp_err   = (pend_addr == err_addr);
                pend              = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && bus.ifu_out_valid && bus.ifu_out_ready) begin
            n_asserts++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL out_unexpected observed_pc=%h expected=none", bus.ifu_out_pc);
            end
            if (sb.size() != 0) begin
                ifu_out_t e;
                e = sb.pop_front();
                check("out_inst", bus.ifu_out_inst, e.inst);
                check("out_pc", bus.ifu_out_pc, e.pc);
                check("out_fault", 32'(bus.ifu_out_fault), 32'(e.fault));
                dq.push_back(cyc);
            end
        end
    end

    initial begin
        rst_b             = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_data  = '0;
        bus.ifu_rsp_err   = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = '0;
        bus.ifu_out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_valid", 32'(bus.ifu_req_valid), 32'd0);
        check("rst_req_addr", bus.ifu_req_addr, 32'h8000_0000);
        check("rst_out_valid", 32'(bus.ifu_out_valid), 32'd0);
        check("rst_out_pc", bus.ifu_out_pc, 32'h0);

        // 1: streaming, one instruction every two cycles
        grant_left = 3;
        sb.push_back(exp_ok(32'h8000_0000));
        sb.push_back(exp_ok(32'h8000_0004));
        sb.push_back(exp_ok(32'h8000_0008));
        dq.delete();
        step();
        rst_b = 1'b1;
        @(negedge clk);
        check("t1_first_req_valid", 32'(bus.ifu_req_valid), 32'd1);
        wait_drain("t1", 40);
        check("t1_cadence_a", 32'(dq[1] - dq[0]), 32'd2);
        check("t1_cadence_b", 32'(dq[2] - dq[1]), 32'd2);

        // 2: decode backpressure holds output and blocks further requests
        step();
        bus.ifu_out_ready = 1'b0;
        grant_left        = 2;
        sb.push_back(exp_ok(32'h8000_000C));
        sb.push_back(exp_ok(32'h8000_0010));
        wait_out_valid("t2", 20);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_pc", bus.ifu_out_pc, 32'h8000_000C);
            check("t2_hold_inst", bus.ifu_out_inst, mem_word(32'h8000_000C));
            check("t2_no_req", 32'(bus.ifu_req_valid), 32'd0);
            @(negedge clk);
        end
        step();
        bus.ifu_out_ready = 1'b1;
        wait_drain("t2", 40);

        // 3: redirect while waiting; the late response is discarded
        step();
        rsp_lat    = 2;
        grant_left = 2;
        sb.push_back(exp_ok(32'h8000_0100));
        wait_req_hs("t3", 20);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0100;
        step();
        bus.redirect = 1'b0;
        wait_drain("t3", 40);
        rsp_lat = 1;

        // 4: misaligned redirect faults without touching imem, then idles
        step();
        bus.ifu_out_ready = 1'b0;
        bus.redirect      = 1'b1;
        bus.redirect_pc   = 32'h8000_0102;
        sb.push_back(exp_flt(32'h8000_0102));
        step();
        bus.redirect = 1'b0;
        wait_out_valid("t4", 20);
        for (int i = 0; i < 4; i++) begin
            check("t4_fault", 32'(bus.ifu_out_fault), 32'd1);
            check("t4_pc", bus.ifu_out_pc, 32'h8000_0102);
            check("t4_inst", bus.ifu_out_inst, 32'h0000_0013);
            check("t4_no_req", 32'(bus.ifu_req_valid), 32'd0);
            @(negedge clk);
        end

        // 6a: redirect coinciding with an output handshake still delivers the held entry
        // 5: access fault on 0x80000008 stalls until the next redirect
        step();
        bus.ifu_out_ready = 1'b1;
        bus.redirect      = 1'b1;
        bus.redirect_pc   = 32'h8000_0000;
        grant_left        = 3;
        err_addr          = 32'h8000_0008;
        sb.push_back(exp_ok(32'h8000_0000));
        sb.push_back(exp_ok(32'h8000_0004));
        sb.push_back(exp_flt(32'h8000_0008));
        step();
        bus.redirect = 1'b0;
        wait_drain("t5", 40);
        grant_left = 1;
        for (int i = 0; i < 3; i++) begin
            check("t5_stall_no_req", 32'(bus.ifu_req_valid), 32'd0);
            @(negedge clk);
        end
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0200;
        sb.push_back(exp_ok(32'h8000_0200));
        step();
        bus.redirect = 1'b0;
        wait_drain("t5b", 40);

        // 6b: redirect in the same cycle as the response drops that response
        step();
        grant_left = 1;
        wait_req_hs("t6", 20);
        step();
        check("t6_rsp_same_cycle", 32'(bus.ifu_rsp_valid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0400;
        grant_left      = 1;
        sb.push_back(exp_ok(32'h8000_0400));
        step();
        bus.redirect = 1'b0;
        wait_drain("t6", 40);

        // 7: request accepted during redirect is flushed; fetch PC wraps past the top
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        grant_left      = 3;
        sb.push_back(exp_ok(32'hFFFF_FFFC));
        sb.push_back(exp_ok(32'h0000_0000));
        step();
        bus.redirect = 1'b0;
        wait_drain("t7", 40);
        check("t7_wrap_next_addr", bus.ifu_req_addr, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
